// File: rtl/seg7_display_arbiter.sv
// Shares the 4-digit seven-segment buffer between two requesters (A: CPU, B: mouse)
// with req/ack handshake, round-robin tie-break and minimum hold, and scans digits out.
module seg7_display_arbiter #(
  parameter int SCAN_DIV   = 250000,
  parameter int HOLD_TICKS = 200
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic [3:0]  dots_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [3:0]  dots_b,
  output logic        ack_b,
  output logic        owner,
  output logic        scan_tick,
  output logic [1:0]  seg_select,
  output logic [3:0]  bin,
  output logic        dot
);
  localparam int NUM_DIGITS = 4;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef struct packed {
    logic        req;
    logic [15:0] data;
    logic [3:0]  dots;
  } disp_req_t;

  typedef enum logic {IDLE, HOLD} state_t;

  disp_req_t rq_a, rq_b;
  assign rq_a = '{req: req_a, data: data_a, dots: dots_a};
  assign rq_b = '{req: req_b, data: data_b, dots: dots_b};

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_grant_q;   // 0 = A, 1 = B
  logic          elig_a, elig_b, grant_a, grant_b, ld;
  logic [SW-1:0] scan_cnt;

  logic [NUM_DIGITS-1:0][3:0] ld_nib;
  logic [NUM_DIGITS-1:0]      ld_dots;
  logic [NUM_DIGITS-1:0][3:0] buf_nib;
  logic [NUM_DIGITS-1:0]      buf_dp;

  // A requester's level is masked while its ack is out, so the still-high req is not re-granted.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    elig_a  = rq_a.req & ~ack_a;
    elig_b  = rq_b.req & ~ack_b;
    case (state_q)
      IDLE: begin
        grant_a = elig_a & (~elig_b | last_grant_q);
        grant_b = elig_b & (~elig_a | ~last_grant_q);
        if (grant_a | grant_b) begin
          state_d = HOLD;
          hold_d  = HOLD_LAST;
        end
      end
      HOLD: begin
        grant_a = elig_a & ~owner;
        grant_b = elig_b & owner;
        if (scan_tick) begin
          if (hold_q == '0) state_d = IDLE;
          else              hold_d  = hold_q - HW'(1);
        end
      end
    endcase
  end

  assign ld      = grant_a | grant_b;
  assign ld_nib  = grant_b ? rq_b.data : rq_a.data;
  assign ld_dots = grant_b ? rq_b.dots : rq_a.dots;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      last_grant_q <= 1'b1;
      owner        <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ack_a   <= grant_a;
      ack_b   <= grant_b;
      if (ld) begin
        owner        <= grant_b;
        last_grant_q <= grant_b;
      end
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    always_ff @(posedge clk_sys) begin
      if (rst) begin
        buf_nib[d] <= '0;
        buf_dp[d]  <= 1'b0;
      end else if (ld) begin
        buf_nib[d] <= ld_nib[d];
        buf_dp[d]  <= ld_dots[d];
      end
    end
  end

  // bin/dot lag seg_select by one cycle; the decoder tolerates the one-cycle ghost.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      scan_cnt   <= '0;
      scan_tick  <= 1'b0;
      seg_select <= '0;
      bin        <= '0;
      dot        <= 1'b0;
    end else begin
      scan_tick <= (scan_cnt == SCAN_LAST);
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);
      if (scan_tick) seg_select <= seg_select + 2'd1;
      bin <= buf_nib[seg_select];
      dot <= buf_dp[seg_select];
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter: stimulus pushes expected acks to a queue,
// a negedge monitor pops them and tracks the expected display buffer.
module tb_seg7_display_arbiter;
  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [3:0]  dots_a = '0, dots_b = '0;
  logic        ack_a, ack_b, owner, scan_tick, dot;
  logic [1:0]  seg_select;
  logic [3:0]  bin;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic rst_s = 1'b0;

  typedef struct {
    logic        side;
    logic [15:0] data;
    logic [3:0]  dots;
    int          at;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  logic [15:0] m_buf = '0;
  logic [3:0]  m_dots = '0;
  logic [3:0]  snap_nib = '0;
  logic        snap_dot = 1'b0;

  always #5 clk_sys = ~clk_sys;

  seg7_display_arbiter #(.SCAN_DIV(4), .HOLD_TICKS(3)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .req_a(req_a), .data_a(data_a), .dots_a(dots_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .dots_b(dots_b), .ack_b(ack_b),
    .owner(owner), .scan_tick(scan_tick), .seg_select(seg_select),
    .bin(bin), .dot(dot)
  );

  always @(posedge clk_sys) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic at_cycle(input int n);
    if (cyc > n) begin
      total++;
      bad++;
      $display("FAIL timeline: at cycle %0d want cycle %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic expect_ack(input logic side, input logic [15:0] d, input logic [3:0] p, input int at);
    exp_t e;
    e.side = side;
    e.data = d;
    e.dots = p;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: bin/dot must equal the model buffer at the digit selected one cycle earlier.
  always @(negedge clk_sys) begin
    chk("ack_exclusive", int'(ack_a & ack_b), 0);
    if (rst_s) begin
      m_buf  = '0;
      m_dots = '0;
      chk("rst_bin", int'(bin), 0);
      chk("rst_dot", int'(dot), 0);
      chk("rst_ack_a", int'(ack_a), 0);
      chk("rst_ack_b", int'(ack_b), 0);
      chk("rst_owner", int'(owner), 0);
      chk("rst_scan_tick", int'(scan_tick), 0);
      chk("rst_seg_select", int'(seg_select), 0);
    end else begin
      chk("bin", int'(bin), int'(snap_nib));
      chk("dot", int'(dot), int'(snap_dot));
      if (ack_a || ack_b) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: ack_a=%0b ack_b=%0b at cycle %0d", ack_a, ack_b, cyc);
        end else begin
          m_e = sb.pop_front();
          chk("ack_side", int'(ack_b), int'(m_e.side));
          chk("ack_cycle", cyc, m_e.at);
          chk("owner", int'(owner), int'(m_e.side));
          m_buf  = m_e.data;
          m_dots = m_e.dots;
        end
      end
    end
    snap_nib = m_buf[int'(seg_select)*4 +: 4];
    snap_dot = m_dots[seg_select];
  end

  initial begin
    // reset for edges 1..3, then scan schedule from a known phase
    at_cycle(3);
    rst = 1'b0;
    at_cycle(4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      chk("scan_tick", int'(scan_tick), (cyc % 4 == 3 && cyc >= 7) ? 1 : 0);
      chk("seg_select", int'(seg_select), ((cyc / 4) - 1) % 4);
    end

    // tie after reset: A first, B after three ticks of A's hold plus two cycles
    at_cycle(24);
    req_a = 1'b1; data_a = 16'hAAAA; dots_a = 4'h3;
    req_b = 1'b1; data_b = 16'hBBBB; dots_b = 4'hC;
    expect_ack(1'b0, 16'hAAAA, 4'h3, 25);
    expect_ack(1'b1, 16'hBBBB, 4'hC, 37);
    at_cycle(26); req_a = 1'b0;
    at_cycle(38); req_b = 1'b0;

    // single grant in IDLE
    at_cycle(48);
    req_a = 1'b1; data_a = 16'h1234; dots_a = 4'h5;
    expect_ack(1'b0, 16'h1234, 4'h5, 49);
    at_cycle(50);
    req_a = 1'b0;
    req_b = 1'b1; data_b = 16'h5A5A; dots_b = 4'h9;

    // owner update while B waits; expiry tick must not move
    at_cycle(52);
    req_a = 1'b1; data_a = 16'hBEEF; dots_a = 4'h6;
    expect_ack(1'b0, 16'hBEEF, 4'h6, 53);
    expect_ack(1'b1, 16'h5A5A, 4'h9, 61);
    at_cycle(54); req_a = 1'b0;
    at_cycle(62); req_b = 1'b0;

    // round robin: A owns and expires, then both request together
    at_cycle(72);
    req_a = 1'b1; data_a = 16'h5678; dots_a = 4'hA;
    expect_ack(1'b0, 16'h5678, 4'hA, 73);
    at_cycle(74); req_a = 1'b0;
    at_cycle(84);
    req_a = 1'b1; data_a = 16'h9999; dots_a = 4'h1;
    req_b = 1'b1; data_b = 16'hCCCC; dots_b = 4'h2;
    expect_ack(1'b1, 16'hCCCC, 4'h2, 85);
    expect_ack(1'b0, 16'h9999, 4'h1, 97);
    at_cycle(86); req_b = 1'b0;
    at_cycle(98); req_a = 1'b0;

    // reset mid-HOLD while B owns, with req_b held through reset
    at_cycle(108);
    req_b = 1'b1; data_b = 16'h7777; dots_b = 4'h3;
    expect_ack(1'b1, 16'h7777, 4'h3, 109);
    at_cycle(110); req_b = 1'b0;
    at_cycle(112);
    rst = 1'b1;
    req_b = 1'b1; data_b = 16'h4321; dots_b = 4'hC;
    expect_ack(1'b1, 16'h4321, 4'hC, 114);
    at_cycle(113); rst = 1'b0;
    at_cycle(115); req_b = 1'b0;

    at_cycle(130);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Shares the 4-digit seven-segment display between two requesters: A (CPU bus register writes) and B (the PS/2 mouse packet formatter). It holds a 16-bit display buffer with 4 dot bits and arbitrates buffer ownership with a request/acknowledge handshake, round-robin tie-break and a minimum hold time. It also runs the digit-scan scheduler. Its `seg_select`/`bin`/`dot` outputs drive the existing `seg7decoder` directly.

## Interface
- `SCAN_DIV`, 250000: `clk_sys` cycles per digit-scan tick (200 Hz at 50 MHz). Must be ≥2.
- `HOLD_TICKS`, 200: minimum ownership time, in scan ticks (1 s). Must be ≥1.
- `clk_sys` in 1: 50 MHz system clock; the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_a` in 1: requester A level request; held until `ack_a`.
- `data_a` in 16: requester A digit nibbles; digit0 = [3:0] … digit3 = [15:12].
- `dots_a` in 4: requester A dot bits; bit i belongs to digit i.
- `ack_a` out 1: one-cycle pulse; A's data has been latched.
- `req_b`, `data_b`, `dots_b`, `ack_b`: same as the A ports, for requester B.
- `owner` out 1: current buffer owner, 0 = A, 1 = B.
- `scan_tick` out 1: one-cycle pulse every `SCAN_DIV` cycles.
- `seg_select` out 2: digit currently being driven.
- `bin` out 4: nibble for the selected digit.
- `dot` out 1: dot for the selected digit.

## Operation
- Reset state:
  - all outputs 0
  - display buffer and dots 0
  - FSM = IDLE
  - `last_grant` = B, so A wins the first tie
  - scan counter 0, hold counter 0
- FSM states are IDLE and HOLD.
- IDLE:
  - Only one eligible request: grant it.
  - Both eligible: grant the requester that is not `last_grant`.
  - On a grant: latch that requester's data and dots into the buffer, pulse its ack, set `owner` and `last_grant`, load hold counter = `HOLD_TICKS`-1, go to HOLD.
- HOLD:
  - A request from the current owner is accepted at once: latch and ack. The hold counter is not restarted.
  - A request from the non-owner waits.
  - On each `scan_tick`: if hold counter = 0, go to IDLE; otherwise decrement it.
  - A waiting request is granted in IDLE on the cycle after the FSM returns there.
- Handshake rules:
  - A requester keeps `req` high, with data stable, until it sees `ack`.
  - It drops `req` on the cycle after `ack`.
  - The arbiter ignores `req_x` for exactly one cycle after `ack_x` (lockout), which tolerates registered requesters.
  - `ack_a` and `ack_b` are never high together.
- Scan:
  - Counter runs 0..`SCAN_DIV`-1 and wraps.
  - `scan_tick` is registered and is high for the cycle after the counter reaches `SCAN_DIV`-1.
  - `seg_select` increments on `scan_tick` and wraps 3→0.
- Output mux:
  - `bin`/`dot` are registered from buffer[`seg_select`].
  - They follow `seg_select` by one cycle. `seg_select` itself is not delayed.
- A buffer update is visible on `bin`/`dot` no later than 1 cycle after its ack, for the digit currently selected.

## Timing
- Request in IDLE at edge N (requester outside lockout):
  - `ack` is high in cycle N+1.
  - The buffer and `owner` are updated at the same edge.
  - `bin`/`dot` reflect the new data from N+2.
- Owner request during HOLD: same one-cycle latency as in IDLE.
- Hold duration is `HOLD_TICKS` scan ticks after the grant. The first tick after the grant counts, even if it arrives one cycle later.
- Hold expiry on the same cycle as an owner request: the owner request is acked first, then the FSM enters IDLE.
- A non-owner request pending at expiry is acked 2 cycles after the expiring `scan_tick` (IDLE entry, then grant).
- `rst` mid-HOLD:
  - Next edge: FSM IDLE, buffer cleared, no ack pulse.
  - Requests still high are arbitrated from the first cycle after `rst` falls.
  - `last_grant` returns to B.
- `rst` asserted during an ack cycle: the ack drops on the next edge and the buffer is cleared.

## Test plan
Simulation parameters: `SCAN_DIV`=4, `HOLD_TICKS`=3.
- **Reset:**
  - Stimulus: hold `rst` 3 cycles, then release.
  - Required response: all outputs 0; `scan_tick` every 4th cycle; `seg_select` steps 0,1,2,3,0.
- **Single grant:**
  - Stimulus: `req_a` with `data_a`=0x1234, `dots_a`=0x5.
  - Required response: `ack_a` for 1 cycle one cycle after `req_a`; `owner`=0; `bin` per digit 4,3,2,1; `dot` per digit 1,0,1,0.
- **Tie after reset:**
  - Stimulus: `req_a` (0xAAAA) and `req_b` (0xBBBB) raised together.
  - Required response: `ack_a` first; `ack_b` only after 3 `scan_tick`s, +2 cycles; then `owner`=1 and `bin`=0xB on all digits.
- **Owner update during hold:**
  - Stimulus: while A owns the buffer and `req_b` is pending, A requests 0xBEEF.
  - Required response: `ack_a` the next cycle; display shows F,E,E,B; B still waits; hold expiry tick is unchanged.
- **Round robin:**
  - Stimulus: after A's hold expires in IDLE, both requesters request on the same cycle.
  - Required response: B is granted.
- **Reset mid-HOLD:**
  - Stimulus: pulse `rst` 1 cycle while B owns the buffer; `req_b` stays high.
  - Required response: buffer clears to 0; after `rst` falls, `req_b` is acked the next cycle and `owner`=1.
